// File: rtl/des_ks_pkg.sv
// DES key-schedule constants and bit-permutation helpers shared by the key scheduler.
// Tables use the standard DES numbering: entry values are 1-based source bit positions, bit 1 = MSB.
package des_ks_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [6:0] PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam logic [5:0] PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Position p (1-based, MSB first) of an N-bit vector lives at index N-p.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        logic [5:0]  src;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            src = 6'(7'd64 - PC1_TAB[i]);
            r[6'(55 - i)] = key[src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  src;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            src = 6'(6'd56 - PC2_TAB[i]);
            r[6'(47 - i)] = cd[src];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// Combinational PC-2 selection: 56-bit C||D half-pair down to a 48-bit round subkey.
module des_pc2_perm
    import des_ks_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] k
);

    assign k = pc2(cd);

endmodule

// File: rtl/des_key_sched.sv
// Iterative DES subkey generator: one PC-2 subkey per adv, encrypt (K1..K16) or decrypt (K16..K1) order.
// Define KEY_SCHED_TDES_EN for a 48-subkey triple-DES sequence (key2/key3 inputs, pass output).
module des_key_sched
    import des_ks_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        key_vld,
    input  logic [63:0] key,
`ifdef KEY_SCHED_TDES_EN
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic [1:0]  pass,
`endif
    input  logic        decrypt,
    input  logic        adv,
    output logic [47:0] k,
    output logic        k_vld,
    output logic [3:0]  round,
    output logic        last,
    output logic        busy
);

    state_e      state;
    state_e      state_nxt;
    logic [55:0] cd;
    logic [55:0] cd_nxt;
    logic [55:0] c0d0;
    logic [3:0]  round_nxt;
    logic        dir;
    logic        dir_nxt;
    logic        do_load;
    logic        ld_dir;
    logic [63:0] ld_key;
    logic        at_end;
    logic        final_pass;
    logic [47:0] k_nxt;

`ifdef KEY_SCHED_TDES_EN
    logic [1:0]  pass_nxt;
    logic [1:0]  ld_pass;
    logic [63:0] key1_q;
    logic [63:0] key2_q;
    logic [63:0] key3_q;
    logic        dec_q;

    // Later passes are loaded from these copies, so the key inputs only need to be valid with key_vld.
    always_ff @(posedge clk) begin
        if (key_vld) begin
            key1_q <= key;
            key2_q <= key2;
            key3_q <= key3;
            dec_q  <= decrypt;
        end
    end

    assign final_pass = (pass == 2'd2);
`else
    assign final_pass = 1'b1;
`endif

    assign at_end = dir ? (round == 4'd0) : (round == 4'd15);
    assign k_vld  = (state == RUN);
    assign busy   = k_vld;
    assign last   = k_vld && at_end && final_pass;

    always_comb begin
        state_nxt = state;
        cd_nxt    = cd;
        round_nxt = round;
        dir_nxt   = dir;
        do_load   = 1'b0;
        ld_dir    = decrypt;
        ld_key    = key;
`ifdef KEY_SCHED_TDES_EN
        pass_nxt  = pass;
        ld_pass   = 2'd0;
        ld_key    = decrypt ? key3 : key;
`endif
        if (key_vld) begin
            do_load   = 1'b1;
            state_nxt = RUN;
        end else if (state == RUN && adv) begin
            if (at_end) begin
                if (final_pass) begin
                    state_nxt = IDLE;
                end
`ifdef KEY_SCHED_TDES_EN
                else begin
                    // Each pass flips direction; the middle pass always uses key2.
                    do_load = 1'b1;
                    ld_dir  = ~dir;
                    ld_pass = pass + 2'd1;
                    ld_key  = (pass == 2'd0) ? key2_q : (dec_q ? key1_q : key3_q);
                end
`endif
            end else if (dir) begin
                cd_nxt    = {rotr28(cd[55:28], SHIFT_TAB[round]),
                             rotr28(cd[27:0],  SHIFT_TAB[round])};
                round_nxt = round - 4'd1;
            end else begin
                cd_nxt    = {rotl28(cd[55:28], SHIFT_TAB[round + 4'd1]),
                             rotl28(cd[27:0],  SHIFT_TAB[round + 4'd1])};
                round_nxt = round + 4'd1;
            end
        end
        c0d0 = pc1(ld_key);
        // Decrypt starts from C0D0 itself: the full schedule rotates by 28, so C16D16 == C0D0.
        if (do_load) begin
            dir_nxt   = ld_dir;
            round_nxt = ld_dir ? 4'd15 : 4'd0;
            cd_nxt    = ld_dir ? c0d0 : {rotl28(c0d0[55:28], 2'd1), rotl28(c0d0[27:0], 2'd1)};
`ifdef KEY_SCHED_TDES_EN
            pass_nxt  = ld_pass;
`endif
        end
    end

    des_pc2_perm u_pc2 (
        .cd (cd_nxt),
        .k  (k_nxt)
    );

    // k always equals PC2(cd), so holding cd on stall or after the final step also holds k.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cd    <= '0;
            round <= '0;
            dir   <= 1'b0;
            k     <= '0;
`ifdef KEY_SCHED_TDES_EN
            pass  <= '0;
`endif
        end else begin
            state <= state_nxt;
            cd    <= cd_nxt;
            round <= round_nxt;
            dir   <= dir_nxt;
            k     <= k_nxt;
`ifdef KEY_SCHED_TDES_EN
            pass  <= pass_nxt;
`endif
        end
    end

endmodule
